// File: rtl/digit_split_scheduler_pkg.sv
// Shared definitions for the digit split scheduler.
//  - TEN      : divisor used by the iterative subtract engine
//  - DIGIT_W  : width of one BCD digit
//  - state_e  : scheduler FSM encoding (IDLE / CALC / DONE)
//  - bcd_pack : packs a tens/units pair into one display byte
package digit_split_scheduler_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] TEN = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [2*DIGIT_W-1:0] bcd_pack(input logic [DIGIT_W-1:0] tens,
                                                    input logic [DIGIT_W-1:0] units);
    return {tens, units};
  endfunction

endpackage

// File: rtl/digit_split_scheduler_div10.sv
// Sequential divide/mod-by-10 engine shared by all counter channels.
// Ports:
//  clk, rst_n  clock and asynchronous active-low reset
//  start       load value into the remainder and clear tens
//  value       W-bit operand, captured on start
//  busy        step enable: subtract 10 once per cycle while rem >= 10
//  ready       remainder is below 10, tens/units are final
//  tens        quotient (4 bits is enough for any W up to 7)
//  units       remainder low 4 bits
module div10_seq_core
  import digit_split_scheduler_pkg::*;
#(
  parameter int W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W-1:0]       value,
  input  logic               busy,
  output logic               ready,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] units
);

  localparam logic [W-1:0] TEN_W = W'(TEN);

  logic [W-1:0]       rem_r;
  logic [DIGIT_W-1:0] tens_r;

  // Remainder/quotient registers: load on start, then one subtract-10 per stepping cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r  <= {W{1'b0}};
      tens_r <= 4'd0;
    end else if (start) begin
      rem_r  <= value;
      tens_r <= 4'd0;
    end else if (busy && (rem_r >= TEN_W)) begin
      rem_r  <= rem_r - TEN_W;
      tens_r <= tens_r + 4'd1;
    end else begin
      rem_r  <= rem_r;
      tens_r <= tens_r;
    end
  end

  assign ready = (rem_r < TEN_W);
  assign tens  = tens_r;
  assign units = rem_r[DIGIT_W-1:0];

endmodule

// File: rtl/digit_split_scheduler.sv
// Round-robin scheduler that time-shares one div10 engine among N_CH counters
// and keeps a held bank of tens/units BCD digits per channel.
// Ports:
//  clk, rst_n   clock and asynchronous active-low reset
//  req          per-channel 1-cycle pulse: value changed, recompute digits
//  value_flat   channel i value at [i*W +: W], sampled when the channel is granted
//  digits_flat  channel i {tens,units} at [i*8 +: 8], held until rewritten
//  busy         engine is working on a channel (CALC or DONE)
//  done         1-cycle pulse, channel done_ch has just been written
//  done_ch      index of the channel written, meaningful only with done
module digit_split_scheduler
  import digit_split_scheduler_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH*W-1:0] value_flat,
  output logic [N_CH*8-1:0] digits_flat,
  output logic              busy,
  output logic              done,
  output logic [2:0]        done_ch
);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [N_CH-1:0]     pending_r;
  logic [N_CH-1:0]     pending_nxt_s;
  logic [N_CH-1:0]     grant_mask_s;
  logic [2:0]          rr_ptr_r;
  logic [2:0]          ch_r;
  logic [2:0]          pick_idx_s;
  logic [2:0]          pick_cand_s;
  logic                pick_found_s;
  logic                grant_s;
  logic [W-1:0]        core_value_s;
  logic                core_ready_s;
  logic [DIGIT_W-1:0]  core_tens_s;
  logic [DIGIT_W-1:0]  core_units_s;
  logic [N_CH*8-1:0]   digits_r;
  logic                done_r;
  logic [2:0]          done_ch_r;

  // Round-robin picker: first pending channel at or after rr_ptr, wrapping around.
  always_comb begin
    pick_idx_s   = 3'd0;
    pick_found_s = 1'b0;
    pick_cand_s  = 3'd0;
    for (int off = 0; off < N_CH; off++) begin
      pick_cand_s = 3'((int'(rr_ptr_r) + off) % N_CH);
      for (int i = 0; i < N_CH; i++) begin
        if (!pick_found_s && (pick_cand_s == 3'(i)) && pending_r[i]) begin
          pick_found_s = 1'b1;
          pick_idx_s   = pick_cand_s;
        end else begin
          pick_found_s = pick_found_s;
        end
      end
    end
  end

  // Operand mux: the granted channel's current value goes to the engine.
  always_comb begin
    core_value_s = {W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (pick_idx_s == 3'(i)) begin
        core_value_s = value_flat[i*W +: W];
      end else begin
        core_value_s = core_value_s;
      end
    end
  end

  // Next-state logic plus grant generation.
  always_comb begin
    state_nxt_s  = state_r;
    grant_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          grant_s     = 1'b1;
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (core_ready_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Pending update: a req in the grant cycle wins over the clear, so the channel is recomputed again.
  always_comb begin
    grant_mask_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      grant_mask_s[i] = grant_s && (pick_idx_s == 3'(i));
    end
    pending_nxt_s = (pending_r & ~grant_mask_s) | req;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Scheduler bookkeeping, digit bank and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {N_CH{1'b0}};
      rr_ptr_r  <= 3'd0;
      ch_r      <= 3'd0;
      digits_r  <= {(N_CH*8){1'b0}};
      done_r    <= 1'b0;
      done_ch_r <= 3'd0;
    end else begin
      pending_r <= pending_nxt_s;
      done_r    <= (state_r == DONE);
      if (grant_s) begin
        ch_r <= pick_idx_s;
      end
      if (state_r == DONE) begin
        rr_ptr_r  <= 3'((int'(ch_r) + 1) % N_CH);
        done_ch_r <= ch_r;
        for (int i = 0; i < N_CH; i++) begin
          if (ch_r == 3'(i)) begin
            digits_r[i*8 +: 8] <= bcd_pack(core_tens_s, core_units_s);
          end
        end
      end
    end
  end

  div10_seq_core #(.W(W)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (grant_s),
    .value (core_value_s),
    .busy  (state_r == CALC),
    .ready (core_ready_s),
    .tens  (core_tens_s),
    .units (core_units_s)
  );

  assign digits_flat = digits_r;
  assign busy        = (state_r != IDLE);
  assign done        = done_r;
  assign done_ch     = done_ch_r;

endmodule

// File: tb/tb_digit_split_scheduler.sv
// Scoreboard bench for digit_split_scheduler. The driver steps a transaction-level
// model (pending set, round-robin pointer, job duration floor(v/10)+2) and pushes the
// expected channel/digit bank/edge of every completion; a negedge monitor pops and compares.
module tb_digit_split_scheduler;

  localparam int N_CH = 4;
  localparam int W    = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_CH-1:0]   req;
  logic [N_CH*W-1:0] value_flat;
  logic [N_CH*8-1:0] digits_flat;
  logic              busy;
  logic              done;
  logic [2:0]        done_ch;

  always #5 clk = ~clk;

  digit_split_scheduler #(.N_CH(N_CH), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .value_flat  (value_flat),
    .digits_flat (digits_flat),
    .busy        (busy),
    .done        (done),
    .done_ch     (done_ch)
  );

  typedef struct {
    int                ch;
    logic [N_CH*8-1:0] bank;
    int                at_edge;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_tests  = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  bit                m_pend[N_CH];
  int                m_rr, m_cnt, m_ch, m_val;
  bit                m_active;
  logic [N_CH*8-1:0] m_bank;
  bit                exp_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, expv, edge_cnt);
    end
  endtask

  task automatic set_val(input int ch, input int v);
    value_flat[ch*W +: W] = W'(v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) m_pend[i] = 1'b0;
    m_rr = 0; m_cnt = 0; m_ch = 0; m_val = 0; m_active = 1'b0;
    m_bank = '0; exp_busy = 1'b0;
    exp_q.delete();
  endtask

  function automatic bit pend_any();
    bit a = 1'b0;
    for (int i = 0; i < N_CH; i++) a |= m_pend[i];
    return a;
  endfunction

  // Apply req for one clock edge and advance the reference model across that edge.
  task automatic step(input logic [N_CH-1:0] r);
    exp_t e;
    int   c;
    req = r;
    @(posedge clk);
    edge_cnt++;
    if (m_active) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_bank[m_ch*8 +: 8] = {4'(m_val / 10), 4'(m_val % 10)};
        e.ch = m_ch; e.bank = m_bank; e.at_edge = edge_cnt;
        exp_q.push_back(e);
        m_rr = (m_ch + 1) % N_CH;
        m_active = 1'b0;
      end
    end else begin
      for (int off = 0; off < N_CH; off++) begin
        c = (m_rr + off) % N_CH;
        if (!m_active && m_pend[c]) begin
          m_pend[c] = 1'b0;
          m_ch      = c;
          m_val     = int'(value_flat[c*W +: W]);
          m_cnt     = m_val / 10 + 2;
          m_active  = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_CH; i++) if (r[i]) m_pend[i] = 1'b1;
    exp_busy = m_active;
    #1 req = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0);
  endtask

  // Monitor: compare busy every cycle and every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy", 64'(busy), 64'(exp_busy));
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got done_ch=%0d, expected no done (edge %0d)", done_ch, edge_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_ch",   64'(done_ch),     64'(mon_e.ch));
          check("digits",    64'(digits_flat), 64'(mon_e.bank));
          check("done_edge", 64'(edge_cnt),    64'(mon_e.at_edge));
        end
      end else if (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
        mon_e = exp_q.pop_front();
        n_tests++; n_fail++;
        $display("FAIL missing_done: got no done, expected ch=%0d at edge %0d", mon_e.ch, mon_e.at_edge);
      end
    end
  end

  initial begin
    int vals[5];
    rst_n = 1'b0; req = '0; value_flat = '0;
    model_reset();
    #22;
    check("rst_digits",  64'(digits_flat), 64'd0);
    check("rst_busy",    64'(busy),        64'd0);
    check("rst_done",    64'(done),        64'd0);
    check("rst_done_ch", 64'(done_ch),     64'd0);
    rst_n = 1'b1;
    idle(2);

    // Single request on ch1 with value 47.
    set_val(1, 47);
    step(4'b0010); idle(12);

    // All channels at once.
    set_val(0, 5); set_val(1, 59); set_val(2, 23); set_val(3, 0);
    step(4'b1111); idle(30);

    // Serve ch2, then ch0 and ch3 together: ch3 must go first.
    set_val(2, 12); set_val(0, 40); set_val(3, 33);
    step(4'b0100); idle(8);
    step(4'b1001); idle(20);

    // Re-request ch0 while it is in the engine with a changed value.
    set_val(0, 30);
    step(4'b0001); idle(2);
    set_val(0, 31);
    step(4'b0001); idle(15);

    // Boundary values on ch3.
    vals = '{9, 10, 19, 60, 63};
    foreach (vals[k]) begin
      set_val(3, vals[k]);
      step(4'b1000); idle(12);
    end

    // Reset in the middle of a 63 computation.
    set_val(2, 63);
    step(4'b0100); idle(3);
    rst_n = 1'b0;
    #1;
    check("midrst_digits", 64'(digits_flat), 64'd0);
    check("midrst_busy",   64'(busy),        64'd0);
    check("midrst_done",   64'(done),        64'd0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    idle(6);

    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      logic [N_CH-1:0] r;
      if ($urandom_range(0, 3) == 0) set_val(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 63)));
      for (int i = 0; i < N_CH; i++) r[i] = ($urandom_range(0, 11) == 0);
      step(r);
    end

    // Drain with a bounded budget.
    for (int k = 0; k < 300 && (m_active || pend_any()); k++) step('0);
    idle(3);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_idle", 64'(m_active || pend_any()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
